filter_window_sequencer: RTL and testbench
==========================================

// Module: filter_window_sequencer
// PURPOSE
//  Frame-level controller for the 3x3 RGB444 neighbourhood filter. Walks a WIDTH x HEIGHT
//  source frame in raster order, fetches the 9 neighbours of each pixel from the source
//  frame RAM, and packs them into the filter's 108-bit window bus. It then waits out the
//  filter pipeline latency and writes the filtered pixel to the destination frame RAM.
//  Sits between the frame buffers and the filter datapath; driven by a start/done handshake.
// PARAMETERS
//  WIDTH     160  frame width in pixels (>=2)
//  HEIGHT    120  frame height in pixels (>=2)
//  ADDR_W    15   frame RAM address width; must satisfy WIDTH*HEIGHT <= 2**ADDR_W
//  PIX_W     12   pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}
//  FILT_LAT  3    clocks from win_valid to filt_data being valid (>=1)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  reset      in   1         asynchronous, active-high
//  start      in   1         1-cycle pulse: begin one frame pass; ignored while busy
//  busy       out  1         high from the cycle after accepted start until done
//  done       out  1         1-cycle pulse after the last destination write
//  rd_en      out  1         source RAM read strobe
//  rd_addr    out  ADDR_W    source RAM address, y*WIDTH+x
//  rd_data    in   PIX_W     source RAM data, valid exactly 1 clk after rd_en
//  win_data   out  9*PIX_W   packed window to filter (held stable between windows)
//  win_valid  out  1         1-cycle pulse, win_data complete
//  filt_data  in   PIX_W     filter output, sampled FILT_LAT clks after win_valid
//  wr_en      out  1         destination RAM write strobe
//  wr_addr    out  ADDR_W    destination address, y*WIDTH+x of centre pixel
//  wr_data    out  PIX_W     filtered pixel
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, win_valid, wr_en = 0; rd_addr, wr_addr, wr_data,
//   win_data = 0; x, y, row base cleared. Reset mid-frame aborts immediately; no done.
//  States: IDLE -> FETCH (9 clks) -> LAND (1) -> ISSUE (1) -> WAIT (FILT_LAT) -> WRITE (1)
//   -> FETCH of next pixel, or -> DONE (1) -> IDLE after pixel (WIDTH-1,HEIGHT-1).
//   Per-pixel cost is 12+FILT_LAT clks. Default frame: 19200*15 = 288000 clks + 2.
//  IDLE: start=1 -> FETCH at x=0, y=0; busy rises the same edge.
//  FETCH: rd_en=1 every cycle, k=0..8 read in order: centre, left, right, up, down,
//   upleft, upright, downleft, downright.
//  Capture: rd_data returned for read k lands in win_data[(9-k)*PIX_W-1 -: PIX_W], i.e.
//   centre [107:96], left [95:84], right [83:72], up [71:60], down [59:48],
//   upleft [47:36], upright [35:24], downleft [23:12], downright [11:0].
//   The read issued in the last FETCH cycle lands during LAND; rd_en=0 in LAND.
//  Border: neighbour coordinates are clamped (replicate edge), e.g. x-1 at x=0 -> x=0;
//   y+1 at y=HEIGHT-1 -> HEIGHT-1. Corners clamp both axes.
//  Address: rd_addr = row_base(ny)+nx. Row bases are kept as registers, incremented
//   by WIDTH; no multiplier. All arithmetic is unsigned ADDR_W bits.
//  ISSUE: win_valid=1 for exactly one clk. win_data is unchanged until the next
//   FETCH overwrites it.
//  WAIT: counter runs FILT_LAT clks. filt_data is registered into wr_data at the final
//   WAIT edge.
//  WRITE: wr_en=1 for one clk; wr_addr = centre address; wr_data = filtered pixel.
//   Then x increments; at x=WIDTH-1, x wraps to 0 and y increments.
//  DONE: done=1 for one clk, busy falls at the same edge. start in DONE is ignored.
//  start during busy: ignored, with no effect on the sequence.
// TESTING
//  Use WIDTH=4, HEIGHT=3, FILT_LAT=3, RAM model with pixel = address.
//  1 Reset then idle: all outputs 0; start never asserted -> rd_en/wr_en stay 0.
//  2 Interior pixel (1,1): window = {5,4,6,1,9,0,2,8,10}; wr_addr=5; win_valid 1 pulse.
//  3 Corner (0,0): window = {0,0,1,0,4,0,1,4,5}; corner (3,2): {11,10,11,7,11,6,7,10,11}.
//  4 Full frame: exactly 12 wr_en pulses, addresses 0..11 in order. done 1 clk after
//    last WRITE. busy high for 12*15+1 clks; filter model filt=~centre -> wr_data=~addr.
//  5 start pulsed mid-frame -> ignored, write count still 12. Then start after done
//    -> second identical pass.
//  6 reset asserted during WAIT of pixel 6: outputs zero asynchronously, no done.
//    New start after release restarts at addr 0.

Source files
------------

// File: rtl/filter_window_sequencer.sv
// rtl/filter_window_sequencer.sv - raster walker that fetches 3x3 neighbourhoods, drives the filter and writes results
// Row bases for the up/centre/down rows are kept pre-clamped so every neighbour address is one add.
module filter_window_sequencer #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int ADDR_W   = 15,
  parameter int PIX_W    = 12,
  parameter int FILT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic [9*PIX_W-1:0]   win_data,
  output logic                 win_valid,
  input  logic [PIX_W-1:0]     filt_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [PIX_W-1:0]     wr_data
);

  localparam int WAIT_W = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [ADDR_W-1:0] XMAX    = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] YMAX    = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROWSTEP = ADDR_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAND, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_k;
  logic [3:0]          r_cap_k;
  logic                r_cap_en;
  logic [ADDR_W-1:0]   r_x;
  logic [ADDR_W-1:0]   r_y;
  logic [ADDR_W-1:0]   r_row_up;
  logic [ADDR_W-1:0]   r_row_cur;
  logic [ADDR_W-1:0]   r_row_dn;
  logic                r_last;
  logic [WAIT_W-1:0]   r_wait;

  logic [3:0]          w_sel;
  logic [ADDR_W-1:0]   w_xl;
  logic [ADDR_W-1:0]   w_xr;
  logic [ADDR_W-1:0]   w_row;
  logic [ADDR_W-1:0]   w_col;
  logic [ADDR_W-1:0]   w_nb_addr;

  // Address of the read issued next: k+1 while fetching, otherwise the centre (k=0).
  always_comb begin
    w_sel = (r_state == S_FETCH) ? r_k + 4'd1 : 4'd0;
    w_xl  = (r_x == '0)   ? r_x : r_x - ADDR_W'(1);
    w_xr  = (r_x == XMAX) ? r_x : r_x + ADDR_W'(1);
    w_row = r_row_cur;
    w_col = r_x;
    case (w_sel)
      4'd1:    begin w_row = r_row_cur; w_col = w_xl; end
      4'd2:    begin w_row = r_row_cur; w_col = w_xr; end
      4'd3:    begin w_row = r_row_up;  w_col = r_x;  end
      4'd4:    begin w_row = r_row_dn;  w_col = r_x;  end
      4'd5:    begin w_row = r_row_up;  w_col = w_xl; end
      4'd6:    begin w_row = r_row_up;  w_col = w_xr; end
      4'd7:    begin w_row = r_row_dn;  w_col = w_xl; end
      4'd8:    begin w_row = r_row_dn;  w_col = w_xr; end
      default: begin w_row = r_row_cur; w_col = r_x;  end
    endcase
    w_nb_addr = w_row + w_col;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      r_k       <= '0;
      r_cap_k   <= '0;
      r_cap_en  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_row_up  <= '0;
      r_row_cur <= '0;
      r_row_dn  <= '0;
      r_last    <= 1'b0;
      r_wait    <= '0;
    end else begin
      // RAM returns data one clock after the strobe, so capture trails the read by a cycle.
      r_cap_en <= rd_en;
      r_cap_k  <= r_k;
      if (r_cap_en)
        win_data[(8 - int'(r_cap_k))*PIX_W +: PIX_W] <= rd_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            r_k       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_row_up  <= '0;
            r_row_cur <= '0;
            r_row_dn  <= ROWSTEP;
            r_last    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (r_k == 4'd8) begin
            rd_en   <= 1'b0;
            r_state <= S_LAND;
          end else begin
            r_k     <= r_k + 4'd1;
            rd_addr <= w_nb_addr;
          end
        end
        S_LAND: begin
          win_valid <= 1'b1;
          r_state   <= S_ISSUE;
          wr_addr   <= r_row_cur + r_x;
          // Reads are finished, so step to the next pixel now; wr_addr keeps this one.
          if (r_x == XMAX) begin
            if (r_y == YMAX) begin
              r_last <= 1'b1;
            end else begin
              r_x       <= '0;
              r_y       <= r_y + ADDR_W'(1);
              r_row_up  <= r_row_cur;
              r_row_cur <= r_row_dn;
              r_row_dn  <= (r_y + ADDR_W'(1) == YMAX) ? r_row_dn : r_row_dn + ROWSTEP;
            end
          end else begin
            r_x <= r_x + ADDR_W'(1);
          end
        end
        S_ISSUE: begin
          win_valid <= 1'b0;
          r_wait    <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == WAIT_W'(FILT_LAT - 1)) begin
            wr_data <= filt_data;
            wr_en   <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WRITE: begin
          wr_en <= 1'b0;
          if (r_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_FETCH;
            rd_en   <= 1'b1;
            rd_addr <= w_nb_addr;
            r_k     <= '0;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_window_sequencer.sv
// tb/tb_filter_window_sequencer.sv - self-checking bench for filter_window_sequencer
// Frame RAM, delayed filter and a clamp-based window reference model live here.
module tb_filter_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int FL = 3;
  localparam int AW = 15;
  localparam int PW = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, rd_en, win_valid, wr_en;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [PW-1:0]   rd_data, filt_data, wr_data;
  logic [9*PW-1:0] win_data;

  logic [PW-1:0]   mem [0:N-1];
  logic [PW-1:0]   fpipe [0:FL-1];
  logic [PW-1:0]   filt_mask = 12'hFFF;

  logic [9*PW-1:0] win_q[$];
  logic [AW-1:0]   wa_q[$];
  logic [PW-1:0]   wd_q[$];
  int cyc = 0, busy_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int nchecks = 0, nerrors = 0;

  filter_window_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PIX_W(PW), .FILT_LAT(FL)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_data(win_data), .win_valid(win_valid), .filt_data(filt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= (int'(rd_addr) < N) ? mem[int'(rd_addr)] : 12'hBAD;
    // Output is only meaningful exactly FL clocks after win_valid; otherwise junk.
    fpipe[0] <= win_valid ? (win_data[9*PW-1 -: PW] ^ filt_mask) : 12'($urandom);
    for (int i = 1; i < FL; i++) fpipe[i] <= fpipe[i-1];
  end
  assign filt_data = fpipe[FL-1];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rd_en) rd_cnt++;
    if (win_valid) win_q.push_back(win_data);
    if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); last_wr_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [9*PW-1:0] ref_win(input int x, input int y);
    int dx[9] = '{0, -1, 1, 0, 0, -1, 1, -1, 1};
    int dy[9] = '{0, 0, 0, -1, 1, -1, -1, 1, 1};
    logic [9*PW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[(8-k)*PW +: PW] = mem[clampi(y + dy[k], H-1) * W + clampi(x + dx[k], W-1)];
    return w;
  endfunction

  task automatic clear_mon();
    win_q.delete(); wa_q.delete(); wd_q.delete();
    busy_cnt = 0; rd_cnt = 0; done_cnt = 0;
  endtask

  task automatic run_frame(input bit poke);
    bit seen;
    seen = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; start = poke; end
      else start = poke && ($urandom_range(0, 15) == 0);
    end
    @(negedge clk) start = 1'b0;
    nchecks++;
    if (!seen) begin nerrors++; $display("FAIL frame_done: done seen=0, required 1 within 2000 cycles"); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nchecks++;
    if ({busy, done, rd_en, win_valid, wr_en} !== 5'b0 || rd_addr !== '0 || wr_addr !== '0
        || wr_data !== '0 || win_data !== '0) begin
      nerrors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b win_valid=%b wr_en=%b rd_addr=%0h wr_addr=%0h wr_data=%0h, required all 0",
               busy, done, rd_en, win_valid, wr_en, rd_addr, wr_addr, wr_data);
    end
    reset = 1'b0;
    clear_mon();
    repeat (20) @(negedge clk);
    nchecks++;
    if (rd_cnt !== 0 || wa_q.size() !== 0 || busy_cnt !== 0) begin
      nerrors++;
      $display("FAIL idle_quiet: reads=%0d writes=%0d busy_cycles=%0d, required 0/0/0", rd_cnt, wa_q.size(), busy_cnt);
    end
  endtask

  task automatic test_full_frame();
    logic [9*PW-1:0] exp_c, exp_a, exp_b;
    for (int i = 0; i < N; i++) mem[i] = 12'(i);
    filt_mask = 12'hFFF;
    clear_mon();
    run_frame(0);
    exp_c = {12'd5, 12'd4, 12'd6, 12'd1, 12'd9, 12'd0, 12'd2, 12'd8, 12'd10};
    exp_a = {12'd0, 12'd0, 12'd1, 12'd0, 12'd4, 12'd0, 12'd1, 12'd4, 12'd5};
    exp_b = {12'd11, 12'd10, 12'd11, 12'd7, 12'd11, 12'd6, 12'd7, 12'd10, 12'd11};
    nchecks++;
    if (win_q.size() !== N) begin nerrors++; $display("FAIL win_count: got %0d, required %0d", win_q.size(), N); end
    nchecks++;
    if (win_q[5] !== exp_c) begin nerrors++; $display("FAIL win_interior: got %h, required %h", win_q[5], exp_c); end
    nchecks++;
    if (win_q[0] !== exp_a) begin nerrors++; $display("FAIL win_corner00: got %h, required %h", win_q[0], exp_a); end
    nchecks++;
    if (win_q[11] !== exp_b) begin nerrors++; $display("FAIL win_corner32: got %h, required %h", win_q[11], exp_b); end
    nchecks++;
    if (wa_q.size() !== N) begin nerrors++; $display("FAIL write_count: got %0d, required %0d", wa_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      nchecks++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== ~12'(i)) begin
        nerrors++;
        $display("FAIL write_%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wa_q[i], wd_q[i], i, ~12'(i));
      end
    end
    nchecks++;
    if (busy_cnt !== N*(12+FL)+1) begin nerrors++; $display("FAIL busy_len: got %0d, required %0d", busy_cnt, N*(12+FL)+1); end
    nchecks++;
    if (done_cnt !== 1 || done_cyc !== last_wr_cyc + 1) begin
      nerrors++;
      $display("FAIL done_pulse: count=%0d at cycle %0d, required 1 at cycle %0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
    nchecks++;
    if (rd_cnt !== 9*N) begin nerrors++; $display("FAIL read_count: got %0d, required %0d", rd_cnt, 9*N); end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    run_frame(1);
    nchecks++;
    if (wa_q.size() !== N || done_cnt !== 1) begin
      nerrors++;
      $display("FAIL start_mid_frame: writes=%0d dones=%0d, required %0d/1", wa_q.size(), done_cnt, N);
    end
    for (int i = 0; i < N; i++) begin
      nchecks++;
      if (wa_q[i] !== AW'(i)) begin nerrors++; $display("FAIL start_mid_addr_%0d: got %0d, required %0d", i, wa_q[i], i); end
    end
    clear_mon();
    repeat (30) @(negedge clk);
    nchecks++;
    if (busy_cnt !== 0 || rd_cnt !== 0) begin
      nerrors++;
      $display("FAIL start_in_done: busy_cycles=%0d reads=%0d, required 0/0", busy_cnt, rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a1[$];
    logic [PW-1:0] d1[$];
    for (int i = 0; i < N; i++) mem[i] = 12'($urandom);
    filt_mask = 12'($urandom);
    clear_mon();
    run_frame(0);
    a1 = wa_q; d1 = wd_q;
    clear_mon();
    run_frame(0);
    nchecks++;
    if (wa_q.size() !== N || a1.size() !== N) begin
      nerrors++;
      $display("FAIL b2b_count: pass1=%0d pass2=%0d, required %0d", a1.size(), wa_q.size(), N);
    end
    for (int i = 0; i < N; i++) begin
      nchecks++;
      if (wa_q[i] !== a1[i] || wd_q[i] !== d1[i] || wd_q[i] !== (mem[i] ^ filt_mask)) begin
        nerrors++;
        $display("FAIL b2b_%0d: pass2 %0d/%h pass1 %0d/%h, required %0d/%h", i, wa_q[i], wd_q[i], a1[i], d1[i], i, mem[i] ^ filt_mask);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [9*PW-1:0] exp;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 12'($urandom);
      filt_mask = 12'($urandom);
      clear_mon();
      run_frame(1'($urandom_range(0, 1)));
      nchecks++;
      if (win_q.size() !== N || wa_q.size() !== N) begin
        nerrors++;
        $display("FAIL rand%0d_count: windows=%0d writes=%0d, required %0d", r, win_q.size(), wa_q.size(), N);
      end
      for (int i = 0; i < N; i++) begin
        exp = ref_win(i % W, i / W);
        nchecks++;
        if (win_q[i] !== exp || wa_q[i] !== AW'(i) || wd_q[i] !== (mem[i] ^ filt_mask)) begin
          nerrors++;
          $display("FAIL rand%0d_pix%0d: win=%h addr=%0d data=%h, required win=%h addr=%0d data=%h",
                   r, i, win_q[i], wa_q[i], wd_q[i], exp, i, mem[i] ^ filt_mask);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int reads_at_reset;
    for (int i = 0; i < N; i++) mem[i] = 12'(i);
    filt_mask = 12'hFFF;
    clear_mon();
    hit = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clk);
      if (win_valid && wa_q.size() == 6) hit = 1;
    end
    nchecks++;
    if (!hit) begin nerrors++; $display("FAIL reset_mid_reach: pixel 6 issue seen=0, required 1"); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    reads_at_reset = rd_cnt;
    nchecks++;
    if ({busy, done, rd_en, win_valid, wr_en} !== 5'b0 || rd_addr !== '0 || wr_addr !== '0
        || wr_data !== '0 || win_data !== '0) begin
      nerrors++;
      $display("FAIL reset_async: busy=%b rd_en=%b wr_en=%b rd_addr=%0h wr_addr=%0h wr_data=%0h, required all 0",
               busy, rd_en, wr_en, rd_addr, wr_addr, wr_data);
    end
    @(negedge clk) reset = 1'b0;
    repeat (30) @(negedge clk);
    nchecks++;
    if (done_cnt !== 0 || wa_q.size() !== 6 || rd_cnt !== reads_at_reset) begin
      nerrors++;
      $display("FAIL reset_abort: dones=%0d writes=%0d reads=%0d, required 0/6/%0d", done_cnt, wa_q.size(), rd_cnt, reads_at_reset);
    end
    clear_mon();
    run_frame(0);
    nchecks++;
    if (wa_q.size() !== N || wa_q[0] !== '0 || wd_q[0] !== 12'hFFF || done_cnt !== 1) begin
      nerrors++;
      $display("FAIL reset_restart: writes=%0d first_addr=%0d first_data=%h dones=%0d, required %0d/0/fff/1",
               wa_q.size(), wa_q[0], wd_q[0], done_cnt, N);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_start_ignored();
    test_back_to_back();
    test_random_frames();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
